// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_loader
// Description : Loads an m x n (1..5) byte matrix from a valid/ready stream:
//               row count, column count, then elements in row-major order.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_loader (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [2:0]   m,
    output logic [2:0]   n,
    output logic [199:0] matrix,
    output logic         done,
    output logic         load_error,
    output logic         busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_M    = 3'd1;
    localparam logic [2:0] S_GET_N    = 3'd2;
    localparam logic [2:0] S_GET_DATA = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [2:0]   m_q, m_d;
    logic [2:0]   n_q, n_d;
    logic [2:0]   row_q, row_d;
    logic [2:0]   col_q, col_d;
    logic [199:0] matrix_q, matrix_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic         w_accept;
    logic         w_dim_legal;
    logic [4:0]   w_slot;
    logic [7:0]   w_bit_off;
    logic         w_last_col;
    logic         w_last_row;

    assign in_ready    = (state_q == S_GET_M) || (state_q == S_GET_N) ||
                         (state_q == S_GET_DATA);
    assign busy        = in_ready;
    assign w_accept    = in_valid && in_ready;
    // Full byte compared so values like 0x0B are rejected despite legal low bits.
    assign w_dim_legal = (in_data >= 8'd1) && (in_data <= 8'd5);
    assign w_slot      = (5'(row_q) * 5'd5) + 5'(col_q);
    assign w_bit_off   = {w_slot, 3'b000};
    assign w_last_col  = (col_q == (n_q - 3'd1));
    assign w_last_row  = (row_q == (m_q - 3'd1));

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        row_d    = row_q;
        col_d    = col_q;
        matrix_d = matrix_q;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d  = S_GET_M;
                    m_d      = 3'd0;
                    n_d      = 3'd0;
                    row_d    = 3'd0;
                    col_d    = 3'd0;
                    matrix_d = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_GET_M: begin
                if (w_accept) begin
                    if (w_dim_legal) begin
                        m_d     = in_data[2:0];
                        state_d = S_GET_N;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_GET_N: begin
                if (w_accept) begin
                    if (w_dim_legal) begin
                        n_d     = in_data[2:0];
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        state_d = S_GET_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_GET_DATA: begin
                if (w_accept) begin
                    matrix_d[w_bit_off +: 8] = in_data;
                    // Counters are left on the final element so they never pass 4.
                    if (w_last_col && w_last_row) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (w_last_col) begin
                        col_d = 3'd0;
                        row_d = row_q + 3'd1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            m_q      <= 3'd0;
            n_q      <= 3'd0;
            row_q    <= 3'd0;
            col_q    <= 3'd0;
            matrix_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            n_q      <= n_d;
            row_q    <= row_d;
            col_q    <= col_d;
            matrix_q <= matrix_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign m          = m_q;
    assign n          = n_q;
    assign matrix     = matrix_q;
    assign done       = done_q;
    assign load_error = err_q;

endmodule
`default_nettype wire

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: clk (rising edge), reset.
REQ-002 Ports SHALL be exactly:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a new load; sampled in IDLE, DONE, ERR only
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a byte this cycle
- m  out  3  loaded row count
- n  out  3  loaded column count
- matrix  out  200  packed matrix; element (i,j) at bits [(i*5+j)*8+7 : (i*5+j)*8]
- done  out  1  load complete, outputs stable
- load_error  out  1  illegal dimension received
- busy  out  1  load in progress

Function
REQ-003 A byte SHALL be accepted only in a cycle where in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-004 The FSM SHALL have states IDLE, GET_M, GET_N, GET_DATA, DONE, ERR.
REQ-005 in_ready SHALL be 1 exactly in GET_M, GET_N and GET_DATA, and 0 in IDLE, DONE and ERR.
REQ-006 busy SHALL be 1 exactly in GET_M, GET_N and GET_DATA.
REQ-007 In IDLE, DONE or ERR, start=1 SHALL:
- go to GET_M on the next edge;
- clear matrix, m, n, done, load_error and the row/col counters to 0.
REQ-008 start SHALL be ignored in GET_M, GET_N and GET_DATA.
REQ-009 In GET_M, an accepted byte of value 1..5 SHALL:
- set m to in_data[2:0];
- go to GET_N.
REQ-010 In GET_N, an accepted byte of value 1..5 SHALL:
- set n to in_data[2:0];
- set row=0, col=0;
- go to GET_DATA.
REQ-011 In GET_M or GET_N, an accepted byte of value 0 or >5 (all 8 bits compared) SHALL:
- go to ERR;
- set load_error=1;
- leave m/n at their last legal values, or 0 if none.
REQ-012 In GET_DATA, each accepted byte SHALL be written to matrix slot (row*5+col); all other slots are unchanged.
REQ-013 After each GET_DATA write, the counters SHALL advance:
- if col==n-1: col=0 and row=row+1;
- otherwise col=col+1.
REQ-014 The byte accepted at row==m-1 and col==n-1 SHALL be written, and the FSM SHALL go to DONE on the same edge. done=1 starts the following cycle, i.e. 1 cycle after the last handshake.
REQ-015 Slots with i>=m or j>=n SHALL remain 0 throughout the load and in DONE.
REQ-016 In DONE, done=1, and matrix, m and n SHALL hold constant until start or reset.
REQ-017 In ERR, load_error=1 and done=0 SHALL hold until start or reset.
REQ-018 Back-to-back bytes (in_valid held high) SHALL be accepted one per cycle with no bubbles. A full 5x5 load takes 27 handshake cycles.
REQ-019 A gap in in_valid SHALL stall the FSM with no change to any state.
REQ-020 row and col SHALL each be 3 bits. Counter values never exceed 4 in legal operation.
REQ-021 All outputs SHALL be registered, except in_ready and busy, which are decoded from the state register.

Reset
REQ-022 When reset=1 at a rising edge, the block SHALL enter IDLE with matrix=0, m=0, n=0, done=0, load_error=0, busy=0, in_ready=0 and row=col=0.
REQ-023 Reset SHALL take priority over start and over any handshake in the same cycle.
REQ-024 Reset during GET_DATA SHALL discard the partial matrix.
REQ-025 After reset release, in_valid bytes SHALL be ignored until start is asserted.

Verification
REQ-026 2x3 load:
- stimulus: start; bytes 2, 3, 1..6 with in_valid held high;
- response: done=1 one cycle after byte 6; m=2, n=3; slots 0,1,2,5,6,7 = 1..6; all other slots 0; 8 handshakes total.
REQ-027 5x5 load:
- stimulus: start; bytes 5, 5, 0x01..0x19 back-to-back;
- response: 27 consecutive handshakes; matrix[199:192]=0x19, matrix[7:0]=0x01; done=1.
REQ-028 Illegal dimensions:
- stimulus: start; m=0 → response: load_error=1, in_ready=0, next byte not accepted;
- stimulus: start; m=3, n=6 → response: load_error=1 with m=3, n=0.
REQ-029 Stalled 1x1 load:
- stimulus: bytes 1, 1, 0xAB with in_valid low for 3 cycles between each;
- response: no state change during gaps; matrix[7:0]=0xAB; done=1.
REQ-030 Reset mid-load:
- stimulus: reset asserted after 4 of 9 elements of a 3x3 load;
- response: all outputs 0, IDLE.
- stimulus: start asserted during GET_DATA;
- response: ignored, load continues normally.
REQ-031 Reload from DONE:
- stimulus: in DONE after a 4x4 load, start, then a 1x2 load;
- response: only slots 0 and 1 nonzero; m=1, n=2.
